// File: rtl/decode_queue.sv
// RV32IM decode stage with a DEPTH-entry elastic output queue.
// Optional ZICSR_DECODE_EN macro enables SYSTEM-opcode (CSR/ECALL/EBREAK) decode.
package decode_queue_pkg;
  localparam int INSTR_INVALID = 0;
  localparam int INSTR_LUI     = 1;
  localparam int INSTR_AUIPC   = 2;
  localparam int INSTR_JAL     = 3;
  localparam int INSTR_JALR    = 4;
  localparam int INSTR_BEQ     = 5;
  localparam int INSTR_BNE     = 6;
  localparam int INSTR_BLT     = 7;
  localparam int INSTR_BGE     = 8;
  localparam int INSTR_BLTU    = 9;
  localparam int INSTR_BGEU    = 10;
  localparam int INSTR_LB      = 11;
  localparam int INSTR_LH      = 12;
  localparam int INSTR_LW      = 13;
  localparam int INSTR_LBU     = 14;
  localparam int INSTR_LHU     = 15;
  localparam int INSTR_SB      = 16;
  localparam int INSTR_SH      = 17;
  localparam int INSTR_SW      = 18;
  localparam int INSTR_ADDI    = 19;
  localparam int INSTR_SLTI    = 20;
  localparam int INSTR_SLTIU   = 21;
  localparam int INSTR_XORI    = 22;
  localparam int INSTR_ORI     = 23;
  localparam int INSTR_ANDI    = 24;
  localparam int INSTR_SLLI    = 25;
  localparam int INSTR_SRLI    = 26;
  localparam int INSTR_SRAI    = 27;
  localparam int INSTR_ADD     = 28;
  localparam int INSTR_SUB     = 29;
  localparam int INSTR_SLL     = 30;
  localparam int INSTR_SLT     = 31;
  localparam int INSTR_SLTU    = 32;
  localparam int INSTR_XOR     = 33;
  localparam int INSTR_SRL     = 34;
  localparam int INSTR_SRA     = 35;
  localparam int INSTR_OR      = 36;
  localparam int INSTR_AND     = 37;
  localparam int INSTR_MUL     = 38;
  localparam int INSTR_MULH    = 39;
  localparam int INSTR_MULHSU  = 40;
  localparam int INSTR_MULHU   = 41;
  localparam int INSTR_DIV     = 42;
  localparam int INSTR_DIVU    = 43;
  localparam int INSTR_REM     = 44;
  localparam int INSTR_REMU    = 45;
  localparam int INSTR_CSRRW   = 46;
  localparam int INSTR_CSRRS   = 47;
  localparam int INSTR_CSRRC   = 48;
  localparam int INSTR_CSRRWI  = 49;
  localparam int INSTR_CSRRSI  = 50;
  localparam int INSTR_CSRRCI  = 51;
  localparam int INSTR_ECALL   = 52;
  localparam int INSTR_EBREAK  = 53;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ID_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [ID_W-1:0]            out_instr_id,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic                       out_rs1_valid,
  output logic                       out_rs2_valid,
  output logic                       out_rd_valid,
  output logic [31:0]                out_imm,
  output logic                       out_illegal,
  output logic [CNT_W-1:0]           illegal_cnt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ID_W-1:0] id;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_v;
    logic            rs2_v;
    logic            rd_v;
    logic [31:0]     imm;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  entry_t      dec;
  int unsigned id_n;
  logic        use_rs1, use_rs2, use_rd, zimm;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] imm_n;
  logic        push, pop, dec_illegal;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    id_n    = INSTR_INVALID;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    zimm    = 1'b0;
    imm_n   = '0;
    unique case (op)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: id_n = INSTR_ADD;
          {7'h20, 3'd0}: id_n = INSTR_SUB;
          {7'h00, 3'd1}: id_n = INSTR_SLL;
          {7'h00, 3'd2}: id_n = INSTR_SLT;
          {7'h00, 3'd3}: id_n = INSTR_SLTU;
          {7'h00, 3'd4}: id_n = INSTR_XOR;
          {7'h00, 3'd5}: id_n = INSTR_SRL;
          {7'h20, 3'd5}: id_n = INSTR_SRA;
          {7'h00, 3'd6}: id_n = INSTR_OR;
          {7'h00, 3'd7}: id_n = INSTR_AND;
          {7'h01, 3'd0}: id_n = INSTR_MUL;
          {7'h01, 3'd1}: id_n = INSTR_MULH;
          {7'h01, 3'd2}: id_n = INSTR_MULHSU;
          {7'h01, 3'd3}: id_n = INSTR_MULHU;
          {7'h01, 3'd4}: id_n = INSTR_DIV;
          {7'h01, 3'd5}: id_n = INSTR_DIVU;
          {7'h01, 3'd6}: id_n = INSTR_REM;
          {7'h01, 3'd7}: id_n = INSTR_REMU;
          default:       id_n = INSTR_INVALID;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm_n   = {{20{in_instr[31]}}, in_instr[31:20]};
        case (f3)
          3'd0: id_n = INSTR_ADDI;
          3'd2: id_n = INSTR_SLTI;
          3'd3: id_n = INSTR_SLTIU;
          3'd4: id_n = INSTR_XORI;
          3'd6: id_n = INSTR_ORI;
          3'd7: id_n = INSTR_ANDI;
          3'd1: if (f7 == 7'h00) id_n = INSTR_SLLI;
          default: begin
            if (f7 == 7'h00)      id_n = INSTR_SRLI;
            else if (f7 == 7'h20) id_n = INSTR_SRAI;
          end
        endcase
      end
      7'b0000011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm_n   = {{20{in_instr[31]}}, in_instr[31:20]};
        case (f3)
          3'd0:    id_n = INSTR_LB;
          3'd1:    id_n = INSTR_LH;
          3'd2:    id_n = INSTR_LW;
          3'd4:    id_n = INSTR_LBU;
          3'd5:    id_n = INSTR_LHU;
          default: id_n = INSTR_INVALID;
        endcase
      end
      7'b1100111: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm_n   = {{20{in_instr[31]}}, in_instr[31:20]};
        if (f3 == 3'd0) id_n = INSTR_JALR;
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_n   = {{20{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
        case (f3)
          3'd0:    id_n = INSTR_SB;
          3'd1:    id_n = INSTR_SH;
          3'd2:    id_n = INSTR_SW;
          default: id_n = INSTR_INVALID;
        endcase
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_n   = {{19{in_instr[31]}}, in_instr[31],
                   in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        case (f3)
          3'd0:    id_n = INSTR_BEQ;
          3'd1:    id_n = INSTR_BNE;
          3'd4:    id_n = INSTR_BLT;
          3'd5:    id_n = INSTR_BGE;
          3'd6:    id_n = INSTR_BLTU;
          3'd7:    id_n = INSTR_BGEU;
          default: id_n = INSTR_INVALID;
        endcase
      end
      7'b0110111: begin
        use_rd = 1'b1;
        imm_n  = {in_instr[31:12], 12'b0};
        id_n   = INSTR_LUI;
      end
      7'b0010111: begin
        use_rd = 1'b1;
        imm_n  = {in_instr[31:12], 12'b0};
        id_n   = INSTR_AUIPC;
      end
      7'b1101111: begin
        use_rd = 1'b1;
        imm_n  = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
        id_n   = INSTR_JAL;
      end
`ifdef ZICSR_DECODE_EN
      7'b1110011: begin
        if (f3 == 3'd0) begin
          if (in_instr == 32'h0000_0073)
            id_n = INSTR_ECALL;
          else if (in_instr == 32'h0010_0073)
            id_n = INSTR_EBREAK;
        end else if (f3 != 3'd4) begin
          use_rd  = 1'b1;
          use_rs1 = ~f3[2];
          zimm    = f3[2];
          imm_n   = {20'b0, in_instr[31:20]};
          case (f3)
            3'd1:    id_n = INSTR_CSRRW;
            3'd2:    id_n = INSTR_CSRRS;
            3'd3:    id_n = INSTR_CSRRC;
            3'd5:    id_n = INSTR_CSRRWI;
            3'd6:    id_n = INSTR_CSRRSI;
            default: id_n = INSTR_CSRRCI;
          endcase
        end
      end
`endif
      default: id_n = INSTR_INVALID;
    endcase

    // Illegal encodings carry no operands or immediate downstream.
    if (id_n == INSTR_INVALID) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      zimm    = 1'b0;
      imm_n   = '0;
    end

    dec        = '0;
    dec.pc     = in_pc;
    dec.id     = ID_W'(id_n);
    dec.opcode = op;
    dec.rs1    = (use_rs1 | zimm) ? in_instr[19:15] : 5'd0;
    dec.rs2    = use_rs2 ? in_instr[24:20] : 5'd0;
    dec.rd     = use_rd ? in_instr[11:7] : 5'd0;
    dec.rs1_v  = use_rs1;
    dec.rs2_v  = use_rs2;
    dec.rd_v   = use_rd;
    dec.imm    = imm_n;
  end

  assign dec_illegal = (id_n == INSTR_INVALID);
  assign in_ready    = (count_q < CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && dec_illegal && illegal_cnt_q != '1)
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign out_pc        = mem_q[rd_ptr_q].pc;
  assign out_instr_id  = mem_q[rd_ptr_q].id;
  assign out_opcode    = mem_q[rd_ptr_q].opcode;
  assign out_rs1       = mem_q[rd_ptr_q].rs1;
  assign out_rs2       = mem_q[rd_ptr_q].rs2;
  assign out_rd        = mem_q[rd_ptr_q].rd;
  assign out_rs1_valid = mem_q[rd_ptr_q].rs1_v;
  assign out_rs2_valid = mem_q[rd_ptr_q].rs2_v;
  assign out_rd_valid  = mem_q[rd_ptr_q].rd_v;
  assign out_imm       = mem_q[rd_ptr_q].imm;
  assign out_illegal   =
    (mem_q[rd_ptr_q].id == ID_W'(INSTR_INVALID));
  assign illegal_cnt   = illegal_cnt_q;
  assign count         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode, queue flow, flush,
// illegal counting (incl. 2-bit saturation) and async reset.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_instr_id;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_valid, out_rs2_valid, out_rd_valid;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;
  logic [1:0]  count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_imm;
  logic [5:0]  s_out_id;
  logic [6:0]  s_out_opcode;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_rs1_v, s_rs2_v, s_rd_v, s_ill;
  logic [1:0]  s_cnt;
  logic [1:0]  s_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  decode_queue u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr_id(out_instr_id),
    .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_valid(out_rs1_valid),
    .out_rs2_valid(out_rs2_valid),
    .out_rd_valid(out_rd_valid),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt), .count(count)
  );

  decode_queue #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_instr_id(s_out_id),
    .out_opcode(s_out_opcode),
    .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
    .out_rs1_valid(s_rs1_v),
    .out_rs2_valid(s_rs2_v),
    .out_rd_valid(s_rd_v),
    .out_imm(s_out_imm), .out_illegal(s_ill),
    .illegal_cnt(s_cnt), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins,
                     input logic [31:0] pc, input logic ordy,
                     input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI5 = 32'h0050_0093;
  localparam logic [31:0] ADD3  = 32'h0020_81B3;
  localparam logic [31:0] SRAI5 = 32'h4033_5293;
  localparam logic [31:0] CSRRW = 32'h3001_10F3;

  logic [31:0] v_ins [7];
  int          v_id  [7];
  logic [31:0] v_imm [7];
  logic [31:0] q [$];
  logic [31:0] pc;
  logic        acc;

  initial begin
    v_ins[0] = 32'h1234_50B7; v_id[0] = INSTR_LUI;
    v_imm[0] = 32'h1234_5000;
    v_ins[1] = 32'hFE20_9EE3; v_id[1] = INSTR_BNE;
    v_imm[1] = 32'hFFFF_FFFC;
    v_ins[2] = 32'h0020_A423; v_id[2] = INSTR_SW;
    v_imm[2] = 32'h0000_0008;
    v_ins[3] = 32'h0080_00EF; v_id[3] = INSTR_JAL;
    v_imm[3] = 32'h0000_0008;
    v_ins[4] = 32'h0220_81B3; v_id[4] = INSTR_MUL;
    v_imm[4] = 32'h0;
    v_ins[5] = 32'h0200_9093; v_id[5] = INSTR_INVALID;
    v_imm[5] = 32'h0;
    v_ins[6] = 32'h0000_B083; v_id[6] = INSTR_INVALID;
    v_imm[6] = 32'h0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_iready", 32'(in_ready), 1);
    chk("rst_cnt", 32'(illegal_cnt), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_id", 32'(out_instr_id), 0);
    @(negedge clk);
    rst = 1'b0;

    cyc(1, ADDI5, 32'h100, 1, 0);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_id", 32'(out_instr_id), INSTR_ADDI);
    chk("addi_rd", 32'(out_rd), 1);
    chk("addi_rdv", 32'(out_rd_valid), 1);
    chk("addi_rs1", 32'(out_rs1), 0);
    chk("addi_rs1v", 32'(out_rs1_valid), 1);
    chk("addi_rs2v", 32'(out_rs2_valid), 0);
    chk("addi_imm", out_imm, 5);
    chk("addi_pc", out_pc, 32'h100);
    cyc(0, 0, 0, 1, 0);
    chk("addi_pop", 32'(count), 0);

    cyc(1, ADD3, 32'h104, 0, 0);
    cyc(1, SRAI5, 32'h108, 0, 0);
    chk("full_count", 32'(count), 2);
    chk("full_iready", 32'(in_ready), 0);
    chk("add_id", 32'(out_instr_id), INSTR_ADD);
    chk("add_rs1", 32'(out_rs1), 1);
    chk("add_rs2", 32'(out_rs2), 2);
    chk("add_rd", 32'(out_rd), 3);
    cyc(1, ADDI5, 32'h10c, 0, 0);
    chk("held_count", 32'(count), 2);
    chk("held_pc", out_pc, 32'h104);
    cyc(1, ADDI5, 32'h10c, 1, 0);
    chk("pop_count", 32'(count), 1);
    chk("srai_id", 32'(out_instr_id), INSTR_SRAI);
    chk("srai_imm", out_imm, 32'h403);
    chk("srai_rs1", 32'(out_rs1), 6);
    chk("srai_rd", 32'(out_rd), 5);
    cyc(1, ADDI5, 32'h10c, 0, 0);
    chk("refill_count", 32'(count), 2);

    q = {32'h108, 32'h10c};
    pc = 32'h110;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("st_iready", 32'(in_ready), 32'(q.size() < 2));
      acc = (q.size() < 2);
      in_valid = 1'b1; in_instr = ADDI5; in_pc = pc;
      out_ready = 1'b1;
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(pc);
        pc = pc + 4;
      end
      #1;
      chk("st_count", 32'(count), 32'(q.size()));
      if (q.size() > 0) chk("st_pc", out_pc, q[0]);
    end
    chk("st_issued", pc, 32'h124);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("st_drain", 32'(count), 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h0, 32'h200 + 32'(4 * i), 1, 0);
      exp_cnt++;
      chk("ill_flag", 32'(out_illegal), 1);
      chk("ill_id", 32'(out_instr_id), INSTR_INVALID);
      chk("ill_cnt", 32'(illegal_cnt), 32'(exp_cnt));
      chk("sat_cnt", 32'(s_cnt), (i < 3) ? i + 1 : 3);
    end
    cyc(0, 0, 0, 1, 0);

    cyc(1, ADDI5, 32'h300, 0, 0);
    cyc(1, ADDI5, 32'h304, 0, 0);
    chk("fl_pre", 32'(count), 2);
    cyc(1, 32'h0, 32'h308, 0, 1);
    chk("fl_count", 32'(count), 0);
    chk("fl_ovalid", 32'(out_valid), 0);
    chk("fl_iready", 32'(in_ready), 1);
    chk("fl_cnt", 32'(illegal_cnt), 32'(exp_cnt));
    flush = 1'b0;

    cyc(1, CSRRW, 32'h400, 0, 0);
`ifdef ZICSR_DECODE_EN
    chk("csr_id", 32'(out_instr_id), INSTR_CSRRW);
    chk("csr_imm", out_imm, 32'h300);
    chk("csr_rs1", 32'(out_rs1), 2);
    chk("csr_rd", 32'(out_rd), 1);
    chk("csr_ill", 32'(out_illegal), 0);
`else
    exp_cnt++;
    chk("csr_id", 32'(out_instr_id), INSTR_INVALID);
    chk("csr_ill", 32'(out_illegal), 1);
`endif
    chk("csr_cnt", 32'(illegal_cnt), 32'(exp_cnt));
    cyc(0, 0, 0, 1, 0);

    for (int i = 0; i < 7; i++) begin
      cyc(1, v_ins[i], 32'h500 + 32'(4 * i), 1, 0);
      if (v_id[i] == INSTR_INVALID) exp_cnt++;
      chk("vec_id", 32'(out_instr_id), 32'(v_id[i]));
      chk("vec_imm", out_imm, v_imm[i]);
      chk("vec_ill", 32'(out_illegal),
          32'(v_id[i] == INSTR_INVALID));
    end
    cyc(0, 0, 0, 1, 0);
    chk("vec_cnt", 32'(illegal_cnt), 32'(exp_cnt));

    cyc(1, ADDI5, 32'h600, 0, 0);
    cyc(1, SRAI5, 32'h604, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_ovalid", 32'(out_valid), 0);
    chk("arst_iready", 32'(in_ready), 1);
    chk("arst_cnt", 32'(illegal_cnt), 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_rd", 32'(out_rd), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
